// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//
// Shares one UART transmitter among NREQ byte producers. A round-robin
// arbiter accepts bytes into a small circular FIFO; a pacing FSM pops the
// FIFO and pulses the transmitter's write strobe no more often than once per
// frame. The transmitter has no busy output, so this block owns all frame
// timing: strobes are spaced by FRAME_CYC = 11 * (FREQ / BAUD) cycles.
//
// Ports
//   clk_i         in   1          clock
//   rst_i         in   1          asynchronous active-high reset
//   req_valid_i   in   NREQ       requester i has a byte
//   req_data_i    in   8*NREQ     byte of requester i at [8i+7:8i]
//   req_ready_o   out  NREQ       one-hot grant; transfer on valid & ready
//   uart_write_o  out  1          one-cycle write strobe to the transmitter
//   uart_val_o    out  8          byte to the transmitter, held between strobes
//   busy_o        out  1          FIFO non-empty or a frame still in progress
//   fifo_count_o  out  AW+1       current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int FREQ  = 27000000,
  parameter int BAUD  = 115200,
  parameter int NREQ  = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [8*NREQ-1:0]        req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     uart_write_o,
  output logic [7:0]               uart_val_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int BIT_CYC   = FREQ / BAUD;
  localparam int FRAME_CYC = 11 * BIT_CYC;
  localparam int CNT_W     = $clog2(FRAME_CYC) + 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(FRAME_CYC - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [PW:0]      NREQ_W   = (PW + 1)'(NREQ);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Registered state
  logic [PW-1:0]     ptr_q;
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW:0]       count_q;
  logic [7:0]        mem_q [DEPTH];
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              uart_write_q;
  logic [7:0]        uart_val_q;
  logic              busy_q;

  // Next-state / combinational
  logic [PW-1:0]     ptr_d;
  logic [AW:0]       count_d;
  logic              full;
  logic              push;
  logic              pop;
  logic              wait_d;
  logic [7:0]        push_byte;

  // Arbiter signals
  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0]   rot_valid;
  logic              found;
  logic [PW:0]       offset;
  logic [PW:0]       idx_sum;
  logic [PW-1:0]     grant_idx;
  logic [NREQ-1:0]   grant_oh;
  logic [PW:0]       ptr_inc;

  // ---------------------------------------------------------------------
  // Round-robin arbiter. Rotating the doubled valid vector by ptr puts the
  // highest-priority requester at bit 0, so the first set bit is the winner
  // at that offset from ptr.
  // ---------------------------------------------------------------------
  assign full      = (count_q == FULL_CNT);
  assign dbl_valid = {req_valid_i, req_valid_i};
  assign rot_valid = dbl_valid[ptr_q +: NREQ];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot_valid[k]) begin
        found  = 1'b1;
        offset = (PW + 1)'(k);
      end
    end
  end

  always_comb begin
    idx_sum = {1'b0, ptr_q} + offset;
    if (idx_sum >= NREQ_W) begin
      idx_sum = idx_sum - NREQ_W;
    end
    grant_idx = PW'(idx_sum);
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = found && (grant_idx == PW'(i));
    end
  end

  // Grants are withheld while full (registered count) and while in reset so
  // nothing can slip in during an asynchronous reset.
  assign req_ready_o = (full || rst_i) ? '0 : grant_oh;
  assign push        = |(req_valid_i & req_ready_o);

  always_comb begin
    push_byte = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        push_byte = req_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, grant_idx} + (PW + 1)'(1);
    ptr_d   = ptr_q;
    if (push) begin
      ptr_d = (ptr_inc == NREQ_W) ? '0 : PW'(ptr_inc);
    end
  end

  // ---------------------------------------------------------------------
  // Pop decision: an idle FSM pops as soon as the FIFO holds a byte; a
  // waiting FSM pops only when its frame counter has reached zero.
  // ---------------------------------------------------------------------
  assign pop = (count_q != '0) && ((state_q == S_IDLE) || (cnt_q == '0));

  // Frame still in progress after this edge (feeds the registered busy).
  assign wait_d = pop || ((state_q == S_WAIT) && (cnt_q != '0));

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // FIFO pointers and occupancy. Pointers are AW bits wide and wrap
  // naturally because DEPTH is a power of two.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      if (push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_q] <= push_byte;
    end
  end

  // ---------------------------------------------------------------------
  // Pacing FSM with registered transmitter outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      uart_write_q <= 1'b0;
      uart_val_q   <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      uart_write_q <= pop;
      busy_q       <= (count_d != '0) || wait_d;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            uart_val_q <= mem_q[rd_q];
            cnt_q      <= RELOAD;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pop) begin
            // Back-to-back frame: reload and stay in WAIT.
            uart_val_q <= mem_q[rd_q];
            cnt_q      <= RELOAD;
          end else if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign uart_write_o = uart_write_q;
  assign uart_val_o   = uart_val_q;
  assign busy_o       = busy_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Drives uart_tx_sched with small parameters (FRAME_CYC = 110) and compares
// every output, every cycle, with a transaction-level reference model: a byte
// queue, a round-robin pointer and the time of the last emitted strobe.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int FREQ  = 1000;
  localparam int BAUD  = 100;
  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 11 * (FREQ / BAUD);

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [8*NREQ-1:0]      req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   uart_write;
  logic [7:0]             uart_val;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;

  uart_tx_sched #(
    .FREQ (FREQ),
    .BAUD (BAUD),
    .NREQ (NREQ),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .uart_write_o(uart_write),
    .uart_val_o  (uart_val),
    .busy_o      (busy),
    .fifo_count_o(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  byte unsigned    q[$];
  int              mptr;
  bit              have_last;
  int              last_dec;
  int              cyc;
  logic            exp_write;
  logic [7:0]      exp_val;
  logic            exp_busy;
  int              exp_count;
  logic [NREQ-1:0] exp_ready;
  int              strobes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mptr      = 0;
    have_last = 1'b0;
    last_dec  = 0;
    exp_write = 1'b0;
    exp_val   = 8'h00;
    exp_busy  = 1'b0;
    exp_count = 0;
  endtask

  // One clock cycle of the reference model, using the inputs now on the bus.
  task automatic model_step();
    int g;
    g = -1;
    if (q.size() < DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (mptr + k) % NREQ;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    for (int i = 0; i < NREQ; i++) exp_ready[i] = (i == g);
    check("ready", 32'(req_ready), 32'(exp_ready));
    // A byte may go out once the previous frame's full duration has elapsed.
    if (q.size() > 0 && (!have_last || (cyc - last_dec) >= FRAME)) begin
      exp_write = 1'b1;
      exp_val   = q.pop_front();
      have_last = 1'b1;
      last_dec  = cyc;
    end else begin
      exp_write = 1'b0;
    end
    if (g >= 0) begin
      q.push_back(req_data[8*g +: 8]);
      mptr = (g + 1) % NREQ;
    end
    exp_busy  = (q.size() > 0) || (have_last && cyc < last_dec + FRAME);
    exp_count = q.size();
    cyc++;
  endtask

  // mode 0: mask held every cycle, fixed bytes ((i+1)<<4 | i)
  // mode 1: mask on the first cycle only, byte 0xA5
  // mode 2: random subset of mask, random bytes
  task automatic run(input int n, input int mode, input logic [NREQ-1:0] mask);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      check("write", 32'(uart_write), 32'(exp_write));
      check("val",   32'(uart_val),   32'(exp_val));
      check("busy",  32'(busy),       32'(exp_busy));
      check("count", 32'(fifo_count), exp_count);
      if (uart_write === 1'b1) strobes++;
      case (mode)
        0: begin
          req_valid = mask;
          for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'((i + 1) * 16 + i);
        end
        1: begin
          req_valid = (t == 0) ? mask : '0;
          req_data  = {NREQ{8'hA5}};
        end
        default: begin
          req_valid = NREQ'($urandom) & mask;
          req_data  = 32'($urandom);
        end
      endcase
      #1;
      model_step();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_write"}, 32'(uart_write), 32'd0);
    check({tag, "_val"},   32'(uart_val),   32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_ready"}, 32'(req_ready),  32'd0);
  endtask

  // Reset asserted between clock edges; outputs must clear immediately.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("arst");
    model_reset();
    req_valid = '1;
    req_data  = 32'($urandom);
    @(negedge clk);
    #1;
    check_zero("arst_hold");
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b0;
  endtask

  initial begin
    int guard;
    int s0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    cyc       = 0;
    strobes   = 0;
    model_reset();
    #12;
    check_zero("por");
    req_valid = '1;
    #1;
    check("por_ready_valid", 32'(req_ready), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b0;

    // Single byte from requester 2 into an idle block.
    run(9, 0, '0);
    s0 = strobes;
    run(140, 1, 4'b0100);
    check("single_strobes", strobes - s0, 1);

    // All four requesters continuously valid, then drain.
    run(600, 0, 4'b1111);
    run(500, 0, '0);

    // Requesters 1 and 3 only, starting with ptr = 2.
    async_reset();
    run(1, 1, 4'b0010);
    run(600, 0, 4'b1010);

    // Reach three queued bytes mid-frame, then reset asynchronously.
    guard = 0;
    while (!(q.size() == 3 && have_last && cyc < last_dec + FRAME) && guard < 400) begin
      run(1, 0, 4'b1010);
      guard++;
    end
    check("reach_three_queued", 32'(guard < 400), 32'd1);
    async_reset();
    s0 = strobes;
    run(300, 0, '0);
    check("post_reset_strobes", strobes - s0, 0);

    // Random traffic, then drain.
    run(3000, 2, 4'b1111);
    run(600, 0, '0);
    check("drained_count", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
